// File: rtl/pipelined_reduce_gate_if.sv
// rtl/pipelined_reduce_gate_if.sv - operand/result handshake bundle for the reduction tree
interface pipelined_reduce_gate_if #(
  parameter int N_INPUTS = 8,
  parameter int WIDTH    = 4
);
  logic                      in_valid;
  logic                      in_ready;
  logic [1:0]                in_mode;
  logic [N_INPUTS*WIDTH-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;
  logic [1:0]                out_mode;

  // Producer/consumer side: drives operands and result acceptance.
  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_mode
  );

  // Reduction block side.
  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data, out_mode
  );
endinterface

// File: rtl/pipelined_reduce_gate.sv
// rtl/pipelined_reduce_gate.sv - registered binary-tree bitwise AND/OR/XOR/NAND reduction
// The tree is stored heap-style: node 1 is the root (output register), node k has
// children 2k and 2k+1, and indices P..2P-1 are the combinational padded leaves.
// A node at depth d belongs to register stage d; stage 0 is the output stage.
module pipelined_reduce_gate #(
  parameter int N_INPUTS = 8,
  parameter int WIDTH    = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  pipelined_reduce_gate_if.slave bus
);
  localparam int LAT = $clog2(N_INPUTS);
  localparam int P   = 1 << LAT;

  logic             adv;
  logic [WIDTH-1:0] leaf   [P];
  logic [WIDTH-1:0] node_q [1:P-1];
  logic [WIDTH-1:0] node_d [1:P-1];
  logic [LAT-1:0]   valid_q;
  logic [LAT-1:0]   valid_d;
  logic [1:0]       mode_q [LAT];
  logic [1:0]       mode_d [LAT];

  // Whole pipe moves together; it only freezes when a result is waiting on the consumer.
  assign adv           = !valid_q[0] || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = valid_q[0];
  assign bus.out_data  = node_q[1];
  assign bus.out_mode  = mode_q[0];

  // Leaves: real operands, then the identity of the incoming op for the padded slots.
  always_comb begin
    logic pad_ones;
    pad_ones = (bus.in_mode == 2'b00) || (bus.in_mode == 2'b11);
    for (int i = 0; i < P; i++) begin
      leaf[i] = {WIDTH{pad_ones}};
      if (i < N_INPUTS) begin
        leaf[i] = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Each node combines its two children with the mode of the sample sitting in those children.
  always_comb begin
    for (int k = 1; k < P; k++) begin
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] r;
      logic [1:0]       stage_mode;
      int               depth;
      depth      = $clog2(k + 1) - 1;
      stage_mode = bus.in_mode;
      a          = '0;
      b          = '0;
      if (depth != LAT - 1) begin
        stage_mode = mode_q[depth + 1];
      end
      if (2 * k >= P) begin
        a = leaf[2 * k - P];
        b = leaf[2 * k + 1 - P];
      end else begin
        a = node_q[2 * k];
        b = node_q[2 * k + 1];
      end
      case (stage_mode)
        2'b01:   r = a | b;
        2'b10:   r = a ^ b;
        default: r = a & b;
      endcase
      // NAND is an AND tree with a single inversion at the root.
      if (k == 1 && stage_mode == 2'b11) begin
        r = ~r;
      end
      node_d[k] = r;
    end
  end

  // Valid bit and mode travel one stage per advance alongside the data.
  always_comb begin
    valid_d = '0;
    for (int d = 0; d < LAT; d++) begin
      mode_d[d] = 2'b00;
      if (d == LAT - 1) begin
        valid_d[d] = bus.in_valid;
        mode_d[d]  = bus.in_mode;
      end else begin
        valid_d[d] = valid_q[d + 1];
        mode_d[d]  = mode_q[d + 1];
      end
    end
  end

  // Pipeline registers: cleared on reset, shifted as a unit on advance, frozen otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int d = 0; d < LAT; d++) begin
        mode_q[d] <= 2'b00;
      end
      for (int k = 1; k < P; k++) begin
        node_q[k] <= '0;
      end
    end else if (adv) begin
      valid_q <= valid_d;
      mode_q  <= mode_d;
      node_q  <= node_d;
    end
  end
endmodule

// File: tb/tb_pipelined_reduce_gate.sv
// tb/tb_pipelined_reduce_gate.sv - self-checking bench for pipelined_reduce_gate (N=8 and N=3)
module tb_pipelined_reduce_gate;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [5:0] exp_q[$];
  logic [5:0] got_q[$];

  pipelined_reduce_gate_if #(.N_INPUTS(8), .WIDTH(4)) bus8();
  pipelined_reduce_gate_if #(.N_INPUTS(3), .WIDTH(4)) bus3();

  pipelined_reduce_gate #(.N_INPUTS(8), .WIDTH(4)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  pipelined_reduce_gate #(.N_INPUTS(3), .WIDTH(4)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: linear fold over the real operands, NAND = inverted AND. Returns {mode, result}.
  function automatic logic [5:0] model(input int n, input logic [1:0] mode, input logic [31:0] data);
    logic [3:0] acc;
    logic [3:0] op;
    acc = (mode == 2'd0 || mode == 2'd3) ? 4'hF : 4'h0;
    for (int i = 0; i < n; i++) begin
      op = data[i*4 +: 4];
      if (mode == 2'd1) acc = acc | op;
      else if (mode == 2'd2) acc = acc ^ op;
      else acc = acc & op;
    end
    if (mode == 2'd3) acc = ~acc;
    return {mode, acc};
  endfunction

  // One clock on the N=8 instance: record what is accepted and what is delivered.
  task automatic step();
    @(negedge clk);
    if (bus8.in_valid && bus8.in_ready) exp_q.push_back(model(8, bus8.in_mode, bus8.in_data));
    if (bus8.out_valid && bus8.out_ready) got_q.push_back({bus8.out_mode, bus8.out_data});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus8.in_valid = 1'b1; bus8.in_data = $urandom; bus8.in_mode = 2'd1; bus8.out_ready = 1'b1;
    bus3.in_valid = 1'b1; bus3.in_data = 12'hFFF; bus3.in_mode = 2'd0; bus3.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus8.in_valid = 1'b0;
    bus3.in_valid = 1'b0;
    #1;
    n_checks++; if (bus8.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", bus8.out_valid); end
    n_checks++; if (bus8.out_data !== 4'h0) begin n_fail++; $display("FAIL reset_out_data got %h exp 0", bus8.out_data); end
    n_checks++; if (bus8.out_mode !== 2'd0) begin n_fail++; $display("FAIL reset_out_mode got %0d exp 0", bus8.out_mode); end
    n_checks++; if (bus8.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", bus8.in_ready); end
    n_checks++; if (bus3.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset3_out_valid got %b exp 0", bus3.out_valid); end
    repeat (4) begin
      @(posedge clk); #1;
      n_checks++; if (bus8.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_no_emerge got %b exp 0", bus8.out_valid); end
    end
  endtask

  task automatic test_latency_back_to_back();
    logic [5:0] exp_res [2];
    exp_res[0] = {2'd0, 4'hE};
    exp_res[1] = {2'd2, 4'h0};
    bus8.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus8.in_valid = (i < 2);
      if (i == 0) begin bus8.in_mode = 2'd0; bus8.in_data = 32'hFFFF_EFFF; end
      if (i == 1) begin bus8.in_mode = 2'd2; bus8.in_data = 32'h1111_1111; end
      @(posedge clk); #1;
      if (i < 2) begin
        n_checks++; if (bus8.out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early_valid cyc %0d got %b exp 0", i, bus8.out_valid); end
      end else if (i < 4) begin
        n_checks++; if (bus8.out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid cyc %0d got %b exp 1", i, bus8.out_valid); end
        n_checks++; if ({bus8.out_mode, bus8.out_data} !== exp_res[i-2]) begin n_fail++; $display("FAIL lat_result cyc %0d got %h exp %h", i, {bus8.out_mode, bus8.out_data}, exp_res[i-2]); end
      end else begin
        n_checks++; if (bus8.out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_late_valid got %b exp 0", bus8.out_valid); end
      end
    end
  endtask

  task automatic test_padding_n3();
    logic [5:0] exp_res [3];
    logic [11:0] din [3];
    logic [1:0]  mds [3];
    exp_res[0] = {2'd0, 4'hF}; din[0] = 12'hFFF; mds[0] = 2'd0;
    exp_res[1] = {2'd1, 4'h7}; din[1] = 12'h421; mds[1] = 2'd1;
    exp_res[2] = {2'd3, 4'h0}; din[2] = 12'hFFF; mds[2] = 2'd3;
    bus3.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus3.in_valid = (i < 3);
      if (i < 3) begin bus3.in_data = din[i]; bus3.in_mode = mds[i]; end
      @(posedge clk); #1;
      if (i == 0) begin
        n_checks++; if (bus3.out_valid !== 1'b0) begin n_fail++; $display("FAIL n3_early_valid got %b exp 0", bus3.out_valid); end
      end else if (i < 4) begin
        n_checks++; if (bus3.out_valid !== 1'b1) begin n_fail++; $display("FAIL n3_valid cyc %0d got %b exp 1", i, bus3.out_valid); end
        n_checks++; if ({bus3.out_mode, bus3.out_data} !== exp_res[i-1]) begin n_fail++; $display("FAIL n3_result cyc %0d got %h exp %h", i, {bus3.out_mode, bus3.out_data}, exp_res[i-1]); end
      end
    end
    bus3.in_valid = 1'b0;
    // Random N=3 samples checked against the fold model (padding must not disturb any op).
    for (int i = 0; i < 12; i++) begin
      logic [5:0] e;
      bus3.in_valid = 1'b1;
      bus3.in_data = 12'($urandom);
      bus3.in_mode = 2'($urandom_range(0, 3));
      e = model(3, bus3.in_mode, {20'h0, bus3.in_data});
      @(posedge clk); #1;
      bus3.in_valid = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (bus3.out_valid !== 1'b1 || {bus3.out_mode, bus3.out_data} !== e) begin n_fail++; $display("FAIL n3_random got v=%b %h exp %h", bus3.out_valid, {bus3.out_mode, bus3.out_data}, e); end
    end
  endtask

  task automatic test_backpressure();
    int sent;
    int stalls;
    logic [5:0] hold;
    exp_q.delete(); got_q.delete();
    sent = 0; stalls = 0; hold = '0;
    for (int cyc = 0; cyc < 200 && got_q.size() < 6; cyc++) begin
      bus8.in_valid = (sent < 6);
      bus8.in_data = $urandom;
      bus8.in_mode = 2'($urandom_range(0, 3));
      if (got_q.size() >= 1 && stalls < 4) begin bus8.out_ready = 1'b0; stalls++; end
      else bus8.out_ready = 1'b1;
      #1;
      if (!bus8.out_ready) begin
        n_checks++; if (bus8.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b exp 0", bus8.in_ready); end
        n_checks++; if (bus8.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid got %b exp 1", bus8.out_valid); end
        if (stalls == 1) hold = {bus8.out_mode, bus8.out_data};
        else begin
          n_checks++; if ({bus8.out_mode, bus8.out_data} !== hold) begin n_fail++; $display("FAIL bp_hold got %h exp %h", {bus8.out_mode, bus8.out_data}, hold); end
        end
      end
      if (bus8.in_valid && bus8.in_ready) sent++;
      step();
    end
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b1;
    n_checks++; if (got_q.size() != 6) begin n_fail++; $display("FAIL bp_count got %0d exp 6", got_q.size()); end
    n_checks++; if (exp_q.size() != 6) begin n_fail++; $display("FAIL bp_accepted got %0d exp 6", exp_q.size()); end
    for (int i = 0; i < 6 && i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_order idx %0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_mixed_modes();
    logic [5:0] exp_res [4];
    exp_res[0] = {2'd0, 4'hA};
    exp_res[1] = {2'd1, 4'hA};
    exp_res[2] = {2'd2, 4'h0};
    exp_res[3] = {2'd3, 4'h5};
    exp_q.delete(); got_q.delete();
    bus8.out_ready = 1'b1;
    bus8.in_data = 32'hAAAA_AAAA;
    for (int i = 0; i < 8; i++) begin
      bus8.in_valid = (i < 4);
      bus8.in_mode = 2'(i);
      step();
    end
    bus8.in_valid = 1'b0;
    n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL mixed_count got %0d exp 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_res[i]) begin n_fail++; $display("FAIL mixed_result idx %0d got %h exp %h", i, got_q[i], exp_res[i]); end
    end
  endtask

  task automatic test_random_stream();
    exp_q.delete(); got_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus8.in_valid = ($urandom_range(0, 9) < 7);
      bus8.in_data = $urandom;
      bus8.in_mode = 2'($urandom_range(0, 3));
      bus8.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b1;
    repeat (8) step();
    n_checks++; if (got_q.size() != exp_q.size() || got_q.size() == 0) begin n_fail++; $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_result idx %0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_midflight_reset();
    logic seen;
    bus8.out_ready = 1'b1;
    bus8.in_mode = 2'd1;
    bus8.in_valid = 1'b1; bus8.in_data = 32'h0000_0003;
    @(posedge clk); #1;
    bus8.in_data = 32'h0000_0030;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = bus8.out_valid;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus8.out_valid !== 1'b0) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midreset_flush got out_valid=%b exp 0", seen); end
    exp_q.delete(); got_q.delete();
    bus8.in_valid = 1'b1; bus8.in_mode = 2'd2; bus8.in_data = $urandom;
    step();
    bus8.in_valid = 1'b0;
    repeat (5) step();
    n_checks++; if (got_q.size() != 1 || exp_q.size() != 1) begin n_fail++; $display("FAIL midreset_new_count got %0d exp 1", got_q.size()); end
    else begin
      n_checks++; if (got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL midreset_new_result got %h exp %h", got_q[0], exp_q[0]); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_latency_back_to_back();
    test_padding_n3();
    test_backpressure();
    test_mixed_modes();
    test_random_stream();
    test_midflight_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
